vliw_bundle_packer: RTL and testbench

Encoder side of the two-slot instruction bundle. It accepts a stream of single 16-bit instructions and pairs one ALU-slot op with one memory-slot op into a 32-bit bundle. ALU ops occupy bits [15:0], so their opcode sits at [4:0]. Memory ops occupy bits [31:16], so their opcode sits at [20:16]. The block sits between the instruction fetch/queue stage and the bundle decoder/control circuit, and fills unpaired slots with NOP.

---
 rtl/vliw_bundle_pkg.sv | 39 +++
 rtl/vliw_op_classifier.sv | 18 +
 rtl/vliw_bundle_packer.sv | 170 +++++++++++++++++
 tb/tb_vliw_bundle_packer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vliw_bundle_pkg.sv
// Shared constants and types for the two-slot bundle packer and the bundle decoder.
// Holds opcode encodings, slot layout, op classes and packer FSM states.
package vliw_bundle_pkg;

  localparam int SLOT_W       = 16;
  localparam int BUNDLE_W     = 32;
  localparam int OPC_W        = 5;
  localparam int ALU_SLOT_LSB = 0;
  localparam int MEM_SLOT_LSB = 16;

  localparam logic [OPC_W-1:0] OP_ALU_RR  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ALU_OFF = 5'b00101;
  localparam logic [OPC_W-1:0] OP_LOAD    = 5'b01010;
  localparam logic [OPC_W-1:0] OP_STORE   = 5'b01011;

  localparam logic [SLOT_W-1:0] SLOT_NOP = 16'h0000;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_MEM,
    CLS_ILLEGAL
  } op_class_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HOLD_ALU,
    ST_HOLD_MEM
  } state_t;

  function automatic logic [BUNDLE_W-1:0] pack_bundle(input logic [SLOT_W-1:0] mem_slot,
                                                      input logic [SLOT_W-1:0] alu_slot);
    logic [BUNDLE_W-1:0] b;
    b = '0;
    b[MEM_SLOT_LSB +: SLOT_W] = mem_slot;
    b[ALU_SLOT_LSB +: SLOT_W] = alu_slot;
    return b;
  endfunction

endpackage

// File: rtl/vliw_op_classifier.sv
// Combinational opcode classifier: maps a 5-bit opcode to ALU, MEM or ILLEGAL.
module vliw_op_classifier
  import vliw_bundle_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output op_class_t        op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    case (opcode)
      OP_ALU_RR, OP_ALU_OFF: op_class = CLS_ALU;
      OP_LOAD, OP_STORE:     op_class = CLS_MEM;
      default:               op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/vliw_bundle_packer.sv
// Pairs one ALU op and one MEM op into a 32-bit bundle, padding lone ops with NOP.
// Optional idle-timeout flush is enabled by defining VLIW_BUNDLE_PACKER_TIMEOUT_EN.
module vliw_bundle_packer
  import vliw_bundle_pkg::*;
#(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SLOT_W-1:0]   in_instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BUNDLE_W-1:0] out_bundle,
  output logic                err_illegal
);

  state_t              r_state;
  state_t              w_state_next;
  logic [SLOT_W-1:0]   r_pending;
  logic [SLOT_W-1:0]   w_pending_next;
  logic                r_out_valid;
  logic [BUNDLE_W-1:0] r_out_bundle;
  logic                r_err;
  logic                w_out_free;
  logic                w_in_xfer;
  logic                w_timeout_hit;
  logic                w_force_flush;
  logic                w_emit;
  logic [BUNDLE_W-1:0] w_emit_bundle;
  op_class_t           w_class;

  vliw_op_classifier u_classifier (
    .opcode   (in_instr[OPC_W-1:0]),
    .op_class (w_class)
  );

  assign w_out_free = ~r_out_valid | out_ready;
  assign in_ready   = w_out_free & ~flush;
  assign w_in_xfer  = in_valid & in_ready;

`ifdef VLIW_BUNDLE_PACKER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
  logic [7:0] r_cnt;

  // Any accepted op (including an illegal one) restarts the idle window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ST_EMPTY || w_in_xfer) begin
      r_cnt <= '0;
    end else if (r_cnt != TIMEOUT_C) begin
      r_cnt <= 8'(r_cnt + 8'd1);
    end
  end

  assign w_timeout_hit = (r_state != ST_EMPTY) && (r_cnt == TIMEOUT_C);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT;
  assign w_timeout_hit    = 1'b0;
`endif

  assign w_force_flush = w_out_free & (flush | w_timeout_hit);

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_emit         = 1'b0;
    w_emit_bundle  = '0;
    if (w_in_xfer) begin
      case (w_class)
        CLS_ALU: begin
          case (r_state)
            ST_EMPTY: begin
              w_state_next   = ST_HOLD_ALU;
              w_pending_next = in_instr;
            end
            ST_HOLD_ALU: begin
              w_emit         = 1'b1;
              w_emit_bundle  = pack_bundle(SLOT_NOP, r_pending);
              w_pending_next = in_instr;
            end
            ST_HOLD_MEM: begin
              w_emit         = 1'b1;
              w_emit_bundle  = pack_bundle(r_pending, in_instr);
              w_state_next   = ST_EMPTY;
              w_pending_next = SLOT_NOP;
            end
            default: w_state_next = ST_EMPTY;
          endcase
        end
        CLS_MEM: begin
          case (r_state)
            ST_EMPTY: begin
              w_state_next   = ST_HOLD_MEM;
              w_pending_next = in_instr;
            end
            ST_HOLD_MEM: begin
              w_emit         = 1'b1;
              w_emit_bundle  = pack_bundle(r_pending, SLOT_NOP);
              w_pending_next = in_instr;
            end
            ST_HOLD_ALU: begin
              w_emit         = 1'b1;
              w_emit_bundle  = pack_bundle(in_instr, r_pending);
              w_state_next   = ST_EMPTY;
              w_pending_next = SLOT_NOP;
            end
            default: w_state_next = ST_EMPTY;
          endcase
        end
        default: begin
          // Illegal op: dropped, state untouched; only the error pulse reacts.
        end
      endcase
    end else if (w_force_flush) begin
      case (r_state)
        ST_HOLD_ALU: begin
          w_emit         = 1'b1;
          w_emit_bundle  = pack_bundle(SLOT_NOP, r_pending);
          w_state_next   = ST_EMPTY;
          w_pending_next = SLOT_NOP;
        end
        ST_HOLD_MEM: begin
          w_emit         = 1'b1;
          w_emit_bundle  = pack_bundle(r_pending, SLOT_NOP);
          w_state_next   = ST_EMPTY;
          w_pending_next = SLOT_NOP;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
    end
  end

  // Emission only happens while the output is free, so a held bundle is never overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_bundle <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_in_xfer && (w_class == CLS_ILLEGAL);
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_bundle <= w_emit_bundle;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_bundle  = r_out_bundle;
  assign err_illegal = r_err;

endmodule

// File: tb/tb_vliw_bundle_packer.sv
// Scoreboard bench for vliw_bundle_packer: stimulus pushes expected bundles, a monitor pops on output transfers.
module tb_vliw_bundle_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = 16'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_bundle;
  logic        err_illegal;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  vliw_bundle_packer #(.TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bundle  (out_bundle),
    .err_illegal (err_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) begin
      n_pass++;
      $display("check %s: got %h", name, act);
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected bundle.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_bundle: got %h expected none", out_bundle);
      end else begin
        chk("bundle", out_bundle, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] ins);
    bit accepted;
    accepted = 1'b0;
    in_valid = 1'b1;
    in_instr = ins;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      $display("FAIL send_timeout: instr %h not accepted within 50 cycles", ins);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_bundle", out_bundle, 32'h0);
    chk("rst_err", 32'(err_illegal), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // ALU + MEM pair, one-cycle valid pulse
    exp_q.push_back(32'h340A_1228);
    send(16'h1228);
    send(16'h340A);
    chk("pair_valid_hi", 32'(out_valid), 32'h1);
    tick(1);
    chk("pair_valid_lo", 32'(out_valid), 32'h0);

    // ALU displaced by ALU, then the new pending pairs with MEM
    exp_q.push_back(32'h0000_1228);
    exp_q.push_back(32'h340A_0045);
    send(16'h1228);
    send(16'h0045);
    send(16'h340A);
    tick(1);

    // Illegal opcode in HOLD_MEM
    send(16'h000B);
    send(16'h001F);
    chk("illegal_pulse", 32'(err_illegal), 32'h1);
    tick(1);
    chk("illegal_pulse_end", 32'(err_illegal), 32'h0);
    chk("illegal_no_bundle", 32'(out_valid), 32'h0);
    exp_q.push_back(32'h000B_1228);
    send(16'h1228);
    tick(1);

    // Lone MEM op: timeout flush or explicit flush
    exp_q.push_back(32'h000B_0000);
    send(16'h000B);
`ifdef VLIW_BUNDLE_PACKER_TIMEOUT_EN
    tick(8);
    chk("timeout_not_early", 32'(out_valid), 32'h0);
    tick(1);
    chk("timeout_flush", 32'(out_valid), 32'h1);
`else
    tick(20);
    chk("no_timeout", 32'(out_valid), 32'h0);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk("flush_emit", 32'(out_valid), 32'h1);
`endif
    tick(1);

    // Backpressure: bundle held stable, input stalled, nothing lost
    out_ready = 1'b0;
    exp_q.push_back(32'h340A_1228);
    send(16'h1228);
    send(16'h340A);
    in_valid = 1'b1;
    in_instr = 16'h0045;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_bundle", out_bundle, 32'h340A_1228);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_q.push_back(32'h340A_0045);
    send(16'h340A);
    tick(1);

    // Reset in HOLD_ALU with an unconsumed bundle held
    send(16'h1228);
    send(16'h0045);
    out_ready = 1'b0;
    chk("pre_reset_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("post_reset_valid", 32'(out_valid), 32'h0);
    chk("post_reset_bundle", out_bundle, 32'h0);
    chk("post_reset_err", 32'(err_illegal), 32'h0);
    out_ready = 1'b1;
    send(16'h340A);
    tick(3);
    chk("mem_unpaired", 32'(out_valid), 32'h0);
    exp_q.push_back(32'h340A_0000);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    tick(1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick(1);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
